gray_ptr_sync: RTL and testbench
================================

# gray_ptr_sync

Parametrised multi-stage synchronizer for gray-coded FIFO pointers crossing into the local clock domain. It samples an asynchronous gray pointer through a configurable flip-flop chain. It then presents the synchronized gray value, its binary equivalent, a per-cycle forward step count and an update pulse. It also flags any illegal multi-bit gray transition. It sits on both sides of the dual-clock FIFO: write pointer into the read domain, read pointer into the write domain.

## Interface
- WIDTH, 4, pointer width in bits (≥2)
- STAGES, 2, synchronizer flip-flop count (≥2)
- RESET_VAL, 0, gray-coded reset value of every pointer stage

- clk  input  1  destination-domain clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- iptr  input  WIDTH  gray pointer from foreign domain; asynchronous to clk
- err_clr  input  1  synchronous clear of sticky error
- optr  output  WIDTH  synchronized gray pointer (last chain stage)
- obin  output  WIDTH  binary equivalent of optr, registered
- ostep  output  WIDTH  forward distance obin(new) − obin(old), mod 2^WIDTH, registered
- oupd  output  1  one-cycle pulse when obin changes
- oerr  output  1  sticky: synchronized gray value changed by more than one bit in one cycle

## Operation
- Chain s[0..STAGES-1]: s[0] <= iptr, s[i] <= s[i-1]; optr = s[STAGES-1]. No logic between chain stages.
- gptr_prev register holds optr of previous cycle.
- Each cycle, compute d = optr XOR gptr_prev.
- obin <= gray2bin(optr), where bin[WIDTH-1] = g[WIDTH-1] and bin[i] = bin[i+1] ^ g[i].
- ostep <= gray2bin(optr) − obin, truncated to WIDTH bits (wrap-around yields a small positive step).
- oupd <= (d != 0).
- oerr set when popcount(d) > 1. Cleared by err_clr. Set takes priority over clear in the same cycle. Otherwise oerr holds.
- On an illegal transition, obin/ostep still update from the sampled value; no filtering.
- Reset (rst=1 at an edge), overriding all else:
  - all s[i] and gptr_prev = RESET_VAL
  - optr = RESET_VAL
  - obin = gray2bin(RESET_VAL)
  - ostep = 0, oupd = 0, oerr = 0
- Reset mid-operation discards all in-flight samples. The first post-reset iptr value propagates with full latency. A difference between iptr and RESET_VAL after reset is a legal single update only if it differs by ≤1 bit.

## Timing
- iptr stable before edge k: s[0] at k, optr valid after edge k+STAGES-1.
- obin, ostep and oupd are valid after edge k+STAGES.
- Latency iptr→optr is STAGES cycles. Latency iptr→obin/oupd/ostep is STAGES+1 cycles.
- oupd is high for exactly one cycle per optr change. Consecutive optr changes on consecutive cycles give consecutive oupd pulses.
- oerr rises in the same cycle as the oupd of the offending transition.
- err_clr takes effect at the next edge; oerr is low the following cycle unless a new error occurs at that edge.
- No combinational path from any input to any output.

## Test plan
- Reset latency, WIDTH=4, STAGES=2: rst, then iptr=0000→0001 before edge 1.
  - optr=0001 after edge 2.
  - obin=1, ostep=1, oupd=1 after edge 3; oupd=0 after edge 4; oerr=0.
- Gray count sweep: iptr walks gray 0..15 one step per cycle.
  - obin follows 0..15 with 3-cycle lag; ostep=1 and oupd=1 every cycle; oerr stays 0.
- Wrap-around: iptr gray 1000 (bin 15) → 0000.
  - obin=0, ostep=1, oupd=1, oerr=0.
- Illegal jump: iptr 0000→0011.
  - obin=2, ostep=2, oupd=1, oerr=1 and held.
  - err_clr pulse with no new error: oerr=0 next cycle.
  - err_clr coincident with a new illegal jump: oerr stays 1.
- Reset mid-flight, STAGES=3, RESET_VAL=0000: iptr=0001, rst asserted one edge after iptr change.
  - All outputs at reset values the next cycle.
  - With iptr still 0001 after rst release: optr=0001 after 3 edges, obin=1, oupd=1 after 4 edges.

Source files
------------

// File: rtl/gray_ptr_sync.sv
// Multi-stage synchronizer for a gray-coded FIFO pointer entering the local clock domain.
// Presents the synchronized gray value, its binary form, the forward step, an update pulse and a sticky error.
module gray_ptr_sync #(
   parameter int                WIDTH     = 4,
   parameter int                STAGES    = 2,
   parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] iptr,
   input  logic             err_clr,
   output logic [WIDTH-1:0] optr,
   output logic [WIDTH-1:0] obin,
   output logic [WIDTH-1:0] ostep,
   output logic             oupd,
   output logic             oerr
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // More than one bit set iff clearing the lowest set bit leaves something behind.
   function automatic logic multi_bit(input logic [WIDTH-1:0] d);
      return ((d & (d - ONE)) != {WIDTH{1'b0}});
   endfunction

   localparam logic [WIDTH-1:0] RESET_BIN = gray2bin(RESET_VAL);

   logic [WIDTH-1:0] sync_r [STAGES];
   logic [WIDTH-1:0] gptr_prev_r;
   logic [WIDTH-1:0] bin_s;
   logic [WIDTH-1:0] diff_s;
   logic             multi_s;

   // Bare flop chain: nothing may sit between stages of a synchronizer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_r[i] <= RESET_VAL;
         end
      end else begin
         sync_r[0] <= iptr;
         for (int i = 1; i < STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   assign optr = sync_r[STAGES-1];

   // Decode and change detection on the synchronized pointer.
   always_comb begin
      bin_s   = gray2bin(optr);
      diff_s  = optr ^ gptr_prev_r;
      multi_s = multi_bit(diff_s);
   end

   // Registered binary view, step and update pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         gptr_prev_r <= RESET_VAL;
         obin        <= RESET_BIN;
         ostep       <= {WIDTH{1'b0}};
         oupd        <= 1'b0;
      end else begin
         gptr_prev_r <= optr;
         obin        <= bin_s;
         ostep       <= bin_s - obin;
         oupd        <= (diff_s != {WIDTH{1'b0}});
      end
   end

   // Sticky error: a new illegal transition wins over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         oerr <= 1'b0;
      end else if (multi_s) begin
         oerr <= 1'b1;
      end else if (err_clr) begin
         oerr <= 1'b0;
      end else begin
         oerr <= oerr;
      end
   end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Self-checking bench for gray_ptr_sync: two instances (2 and 3 stages) compared against
// a history-based reference model, plus directed checks of the documented scenarios.
module tb_gray_ptr_sync;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] iptr;
   logic       err_clr;

   logic [3:0] optr2, obin2, ostep2;
   logic       oupd2, oerr2;
   logic [3:0] optr3, obin3, ostep3;
   logic       oupd3, oerr3;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   gray_ptr_sync #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'b0000)) dut2 (
      .clk(clk), .rst(rst), .iptr(iptr), .err_clr(err_clr),
      .optr(optr2), .obin(obin2), .ostep(ostep2), .oupd(oupd2), .oerr(oerr2));

   gray_ptr_sync #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'b0000)) dut3 (
      .clk(clk), .rst(rst), .iptr(iptr), .err_clr(err_clr),
      .optr(optr3), .obin(obin3), .ostep(ostep3), .oupd(oupd3), .oerr(oerr3));

   // Reference model: the list of values sampled at each edge since the last reset.
   logic [3:0] smp[$];
   int         n_edges = 0;
   bit         started = 1'b0;
   bit         mdl_err[2];
   int         stg[2] = '{2, 3};

   function automatic logic [3:0] to_gray(input int v);
      logic [3:0] b;
      b = 4'(v);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [3:0] g2b(input logic [3:0] g);
      for (int v = 0; v < 16; v++) begin
         if (to_gray(v) == g) return 4'(v);
      end
      return 4'd0;
   endfunction

   // Synchronized pointer seen after edge m for a chain of s stages.
   function automatic logic [3:0] opt_at(input int m, input int s);
      if (m - s >= 0 && m - s < smp.size()) return smp[m-s];
      return 4'b0000;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_dut(input int j, input logic [3:0] op, input logic [3:0] ob,
                            input logic [3:0] os, input logic ou, input logic oe);
      int s;
      logic [3:0] cur, prev;
      s    = stg[j];
      cur  = opt_at(n_edges - 1, s);
      prev = opt_at(n_edges - 2, s);
      chk($sformatf("s%0d_optr", s),  op, opt_at(n_edges, s));
      chk($sformatf("s%0d_obin", s),  ob, g2b(cur));
      chk($sformatf("s%0d_ostep", s), os, g2b(cur) - g2b(prev));
      chk($sformatf("s%0d_oupd", s),  {3'b000, ou}, {3'b000, cur != prev});
      chk($sformatf("s%0d_oerr", s),  {3'b000, oe}, {3'b000, mdl_err[j]});
   endtask

   // One clock: advance the model at the edge, then compare on the falling edge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         smp.delete();
         n_edges    = 0;
         mdl_err[0] = 1'b0;
         mdl_err[1] = 1'b0;
         started    = 1'b1;
      end else begin
         for (int j = 0; j < 2; j++) begin
            logic [3:0] d;
            d = opt_at(n_edges, stg[j]) ^ opt_at(n_edges - 1, stg[j]);
            if ($countones(d) > 1) mdl_err[j] = 1'b1;
            else if (err_clr) mdl_err[j] = 1'b0;
         end
         smp.push_back(iptr);
         n_edges++;
      end
      @(negedge clk);
      if (started) begin
         check_dut(0, optr2, obin2, ostep2, oupd2, oerr2);
         check_dut(1, optr3, obin3, ostep3, oupd3, oerr3);
      end
   endtask

   initial begin
      int cur_bin;
      int r;
      rst     = 1'b1;
      iptr    = 4'b0000;
      err_clr = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_optr", optr2, 4'b0000);
      chk("rst_obin", obin2, 4'b0000);
      chk("rst_ostep", ostep2, 4'b0000);
      chk("rst_oupd", {3'b000, oupd2}, 4'b0000);
      chk("rst_oerr", {3'b000, oerr2}, 4'b0000);

      // Reset latency
      iptr = 4'b0001;
      tick();
      tick();
      chk("lat_optr", optr2, 4'b0001);
      tick();
      chk("lat_obin", obin2, 4'b0001);
      chk("lat_ostep", ostep2, 4'b0001);
      chk("lat_oupd", {3'b000, oupd2}, 4'b0001);
      tick();
      chk("lat_oupd_low", {3'b000, oupd2}, 4'b0000);
      chk("lat_oerr", {3'b000, oerr2}, 4'b0000);

      // Gray count sweep ending in the wrap to 0000
      for (int i = 2; i <= 16; i++) begin
         iptr = to_gray(i % 16);
         tick();
      end
      tick();
      tick();
      chk("wrap_obin", obin2, 4'b0000);
      chk("wrap_ostep", ostep2, 4'b0001);
      chk("wrap_oupd", {3'b000, oupd2}, 4'b0001);
      chk("wrap_oerr", {3'b000, oerr2}, 4'b0000);

      // Illegal jump 0000 -> 0011
      iptr = 4'b0011;
      tick();
      tick();
      tick();
      chk("ill_obin", obin2, 4'b0010);
      chk("ill_ostep", ostep2, 4'b0010);
      chk("ill_oupd", {3'b000, oupd2}, 4'b0001);
      chk("ill_oerr", {3'b000, oerr2}, 4'b0001);
      tick();
      chk("ill_oerr_hold", {3'b000, oerr2}, 4'b0001);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_oerr", {3'b000, oerr2}, 4'b0000);

      // Clear coincident with a new illegal transition 0011 -> 0000
      iptr = 4'b0000;
      tick();
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_vs_set_oerr", {3'b000, oerr2}, 4'b0001);

      // Reset mid-flight on the 3-stage instance
      for (int i = 0; i < 4; i++) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      iptr = 4'b0001;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_optr", optr3, 4'b0000);
      chk("mid_obin", obin3, 4'b0000);
      chk("mid_ostep", ostep3, 4'b0000);
      chk("mid_oupd", {3'b000, oupd3}, 4'b0000);
      chk("mid_oerr", {3'b000, oerr3}, 4'b0000);
      tick();
      tick();
      tick();
      chk("mid_optr_lat", optr3, 4'b0001);
      tick();
      chk("mid_obin_lat", obin3, 4'b0001);
      chk("mid_oupd_lat", {3'b000, oupd3}, 4'b0001);

      // Randomized traffic: mostly legal steps, some holds, illegal jumps, clears and resets
      cur_bin = 1;
      for (int c = 0; c < 600; c++) begin
         r       = int'($urandom_range(0, 31));
         err_clr = 1'b0;
         rst     = 1'b0;
         if (r < 18) begin
            cur_bin = (cur_bin + 1) % 16;
         end else if (r < 22) begin
            cur_bin = cur_bin;
         end else if (r < 26) begin
            cur_bin = int'($urandom_range(0, 15));
         end else if (r < 30) begin
            err_clr = 1'b1;
            cur_bin = (cur_bin + 1) % 16;
         end else if (r < 31) begin
            err_clr = 1'b1;
         end else begin
            rst = ($urandom_range(0, 3) == 0);
         end
         iptr = to_gray(cur_bin);
         tick();
      end
      rst     = 1'b0;
      err_clr = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
